wb_rr_arbiter: RTL and testbench

Two-master round-robin Wishbone arbiter. It shares a single Wishbone slave port between two masters, for example two Avalon-to-Wishbone bridge instances, or a bridge and a DMA engine. Ownership is held for a whole `cyc` period, so bursts and locked sequences are never split. A watchdog terminates stalled cycles with an error so that an unresponsive slave cannot hang the bus.

---
 rtl/wb_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-master round-robin Wishbone arbiter with stall watchdog
// Ownership spans a whole cyc period; an unterminated strobe is ended with err after TIMEOUT cycles.
module wb_rr_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own_cyc, own_stb, slv_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign own_cyc  = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb  = own_cyc & (owner_q ? m1_stb_i : m0_stb_i);
  assign slv_term = s_ack_i | s_err_i | s_rty_i;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i | m1_cyc_i) begin
          // On a tie the master that did not own the bus last time wins.
          owner_d = (m0_cyc_i & m1_cyc_i) ? ~last_q : m1_cyc_i;
          last_d  = owner_d;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant_o  = owner_q ? 2'b10 : 2'b01;
        s_adr_o  = owner_q ? m1_adr_i : m0_adr_i;
        s_dat_o  = owner_q ? m1_dat_i : m0_dat_i;
        s_sel_o  = owner_q ? m1_sel_i : m0_sel_i;
        s_we_o   = owner_q ? m1_we_i  : m0_we_i;
        s_cti_o  = owner_q ? m1_cti_i : m0_cti_i;
        s_bte_o  = owner_q ? m1_bte_i : m0_bte_i;
        s_cyc_o  = own_cyc;
        s_stb_o  = own_stb;
        m0_ack_o = ~owner_q & s_ack_i;
        m0_err_o = ~owner_q & s_err_i;
        m0_rty_o = ~owner_q & s_rty_i;
        m1_ack_o = owner_q & s_ack_i;
        m1_err_o = owner_q & s_err_i;
        m1_rty_o = owner_q & s_rty_i;
        if (own_stb && !slv_term) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        // A slave termination in the last allowed cycle beats the watchdog.
        if (!own_cyc) begin
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && own_stb && !slv_term && (cnt_q == CNT_LAST)) begin
          state_d = TERM;
        end
      end
      TERM: begin
        grant_o   = owner_q ? 2'b10 : 2'b01;
        m0_err_o  = ~owner_q;
        m1_err_o  = owner_q;
        timeout_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb/tb_wb_rr_arbiter.sv - scoreboard bench for wb_rr_arbiter
// Master tasks queue expected terminations; a negedge monitor pops and compares them.
module tb_wb_rr_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int S_ACK = 0, S_ERR = 1, S_RTY = 2, S_NONE = 3, S_MAN = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0;
  logic [DW-1:0] m0_dat_i = '0, m1_dat_i = '0;
  logic [3:0]    m0_sel_i = '0, m1_sel_i = '0;
  logic          m0_we_i = 1'b0, m1_we_i = 1'b0;
  logic          m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
  logic          m0_stb_i = 1'b0, m1_stb_i = 1'b0;
  logic [2:0]    m0_cti_i = '0, m1_cti_i = '0;
  logic [1:0]    m0_bte_i = '0, m1_bte_i = '0;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;
  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [AW-1:0] s_adr_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o, grant_o;

  wb_rr_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    bit          chk_dat;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    bit          to;
  } exp_t;

  exp_t        q0[$], q1[$];
  logic [1:0]  glog[$];
  logic [1:0]  last_g = 2'b00;
  int          total = 0, bad = 0;
  int          slave_mode = S_MAN, slave_delay = 0;
  logic [31:0] slave_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_term(input int m);
    exp_t       e;
    logic [2:0] tv;
    tv = (m == 0) ? {m0_rty_o, m0_err_o, m0_ack_o} : {m1_rty_o, m1_err_o, m1_ack_o};
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL m%0d unexpected termination: got %b expected none", m, tv);
      return;
    end
    if (m == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    chk($sformatf("m%0d term kind", m), 32'(tv), 32'(1 << e.kind));
    if (e.chk_dat) chk($sformatf("m%0d rdata", m), (m == 0) ? m0_dat_o : m1_dat_o, e.dat);
    chk($sformatf("m%0d grant at term", m), 32'(grant_o), (m == 0) ? 32'd1 : 32'd2);
    chk($sformatf("m%0d timeout_o", m), 32'(timeout_o), 32'(e.to));
    chk($sformatf("m%0d s_cyc_o at term", m), 32'(s_cyc_o), 32'(!e.to));
    if (!e.to) begin
      chk($sformatf("m%0d s_adr_o", m), s_adr_o, e.adr);
      chk($sformatf("m%0d s_cti_o", m), 32'(s_cti_o), 32'(e.cti));
      chk($sformatf("m%0d s_we_o", m), 32'(s_we_o), 32'(e.we));
      chk($sformatf("m%0d s_dat_o", m), s_dat_o, ~e.adr);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (grant_o !== last_g) begin
      glog.push_back(grant_o);
      last_g = grant_o;
    end
    if (m0_ack_o | m0_err_o | m0_rty_o) check_term(0);
    if (m1_ack_o | m1_err_o | m1_rty_o) check_term(1);
  end

  initial begin
    int w;
    w = 0;
    forever begin
      @(posedge clk);
      #2;
      if (slave_mode != S_MAN) begin
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        s_dat_i = slave_rdata;
        if (s_stb_o) begin
          if (w == slave_delay && slave_mode != S_NONE) begin
            case (slave_mode)
              S_ACK:   s_ack_i = 1'b1;
              S_ERR:   s_err_i = 1'b1;
              default: s_rty_i = 1'b1;
            endcase
            w = 0;
          end else if (w < 1000) begin
            w++;
          end
        end else begin
          w = 0;
        end
      end
    end
  end

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr;
      m0_cti_i = cti; m0_dat_i = ~adr; m0_sel_i = 4'hF;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr;
      m1_cti_i = cti; m1_dat_i = ~adr; m1_sel_i = 4'hF;
    end
  endtask

  task automatic run_master(input int m, input int beats, input logic we, input logic [31:0] adr,
                            input int kind, input logic [31:0] dat, input bit to);
    exp_t e;
    bit   done;
    for (int b = 0; b < beats; b++) begin
      e.kind    = kind;
      e.chk_dat = !we;
      e.dat     = dat;
      e.adr     = adr + 32'(4 * b);
      e.cti     = (beats == 1) ? 3'b000 : ((b == beats - 1) ? 3'b111 : 3'b010);
      e.we      = we;
      e.to      = to;
      drive(m, 1'b1, 1'b1, we, e.adr, e.cti);
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
        @(negedge clk);
        done = (m == 0) ? (m0_ack_o | m0_err_o | m0_rty_o) : (m1_ack_o | m1_err_o | m1_rty_o);
      end
      if (!done) begin
        total++;
        bad++;
        $display("FAIL m%0d beat %0d wait: got no termination expected one within 60 cycles", m, b);
      end
      @(posedge clk);
      #1;
    end
    drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic settle_and_clear();
    repeat (3) @(posedge clk);
    #1;
    glog.delete();
  endtask

  task automatic check_log(input string name, input int n, input logic [15:0] v);
    chk({name, " grant log length"}, 32'(glog.size()), 32'(n));
    for (int i = 0; i < n && i < glog.size(); i++)
      chk($sformatf("%s grant log[%0d]", name, i), 32'(glog[i]), 32'(v[2*(n-1-i) +: 2]));
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // Reset values, with read data flowing straight to both masters.
    s_dat_i = 32'h12345678;
    #3;
    chk("reset s_cyc_o", 32'(s_cyc_o), 32'd0);
    chk("reset s_stb_o", 32'(s_stb_o), 32'd0);
    chk("reset grant_o", 32'(grant_o), 32'd0);
    chk("reset timeout_o", 32'(timeout_o), 32'd0);
    chk("reset m0_ack_o", 32'(m0_ack_o), 32'd0);
    chk("reset m0_dat_o", m0_dat_o, 32'h12345678);
    chk("reset m1_dat_o", m1_dat_o, 32'h12345678);
    slave_mode = S_ACK;

    // Single read, slave acks after 2 wait cycles.
    do_reset();
    glog.delete();
    slave_delay = 2;
    slave_rdata = 32'hDEADBEEF;
    fork
      run_master(0, 1, 1'b0, 32'h100, S_ACK, 32'hDEADBEEF, 1'b0);
      begin
        @(negedge clk);
        chk("latency s_cyc_o before edge", 32'(s_cyc_o), 32'd0);
        @(negedge clk);
        chk("latency s_cyc_o after edge", 32'(s_cyc_o), 32'd1);
        chk("single s_adr_o", s_adr_o, 32'h100);
      end
    join
    repeat (3) @(posedge clk);
    check_log("single", 2, 16'b01_00);

    // Both masters requesting while reset releases: m0 first, one idle cycle, then m1.
    rst_n = 1'b0;
    #1;
    glog.delete();
    slave_delay = 0;
    slave_rdata = 32'hCAFE0001;
    fork
      run_master(0, 1, 1'b0, 32'h200, S_ACK, 32'hCAFE0001, 1'b0);
      run_master(1, 1, 1'b0, 32'h300, S_ACK, 32'hCAFE0001, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    check_log("tie", 4, 16'b01_00_10_00);

    // Round robin with both masters re-requesting.
    do_reset();
    glog.delete();
    slave_delay = 1;
    slave_rdata = 32'h5A5A0000;
    fork
      begin
        run_master(0, 1, 1'b0, 32'h1000, S_ACK, 32'h5A5A0000, 1'b0);
        @(posedge clk); #1;
        run_master(0, 1, 1'b0, 32'h1004, S_ACK, 32'h5A5A0000, 1'b0);
      end
      begin
        run_master(1, 1, 1'b0, 32'h2000, S_ACK, 32'h5A5A0000, 1'b0);
        @(posedge clk); #1;
        run_master(1, 1, 1'b0, 32'h2004, S_ACK, 32'h5A5A0000, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    check_log("round robin", 8, 16'b01_00_10_00_01_00_10_00);

    // m1 4-beat burst holds the bus while m0 waits.
    do_reset();
    glog.delete();
    slave_delay = 0;
    slave_rdata = 32'h0B0B0B0B;
    fork
      run_master(1, 4, 1'b0, 32'h400, S_ACK, 32'h0B0B0B0B, 1'b0);
      begin
        repeat (2) @(posedge clk); #1;
        run_master(0, 1, 1'b0, 32'h480, S_ACK, 32'h0B0B0B0B, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    check_log("burst", 4, 16'b10_00_01_00);

    // Watchdog: unresponsive slave, err in cycle 16, then m1 served normally.
    do_reset();
    glog.delete();
    slave_mode = S_NONE;
    fork
      run_master(0, 1, 1'b1, 32'h500, S_ERR, 32'h0, 1'b1);
      begin
        int n;
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
          @(negedge clk);
          seen = s_stb_o;
        end
        n = 0;
        while (seen && !m0_err_o && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("watchdog err cycle", 32'(n), 32'd16);
      end
    join
    slave_mode = S_ACK;
    slave_rdata = 32'h66666666;
    run_master(1, 1, 1'b0, 32'h600, S_ACK, 32'h66666666, 1'b0);
    repeat (3) @(posedge clk);
    check_log("watchdog", 4, 16'b01_00_10_00);

    // Ack in the same cycle the counter reaches TIMEOUT-1 wins over the watchdog.
    do_reset();
    slave_delay = 15;
    slave_rdata = 32'h77770000;
    run_master(0, 1, 1'b0, 32'h700, S_ACK, 32'h77770000, 1'b0);
    settle_and_clear();

    // err and rty reach the owner only.
    slave_mode = S_ERR;
    slave_delay = 1;
    slave_rdata = 32'h88880000;
    run_master(1, 1, 1'b0, 32'h800, S_ERR, 32'h88880000, 1'b0);
    settle_and_clear();
    slave_mode = S_RTY;
    run_master(0, 1, 1'b1, 32'h840, S_RTY, 32'h88880000, 1'b0);
    settle_and_clear();

    // Reset asserted mid-burst drops the slave cycle at once and hides terminations.
    slave_mode = S_MAN;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    s_dat_i = 32'h0F0F0F0F;
    drive(1, 1'b1, 1'b1, 1'b0, 32'h900, 3'b010);
    repeat (3) @(negedge clk);
    chk("mid-burst grant_o", 32'(grant_o), 32'd2);
    chk("mid-burst s_cyc_o", 32'(s_cyc_o), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset s_cyc_o", 32'(s_cyc_o), 32'd0);
    chk("async reset s_stb_o", 32'(s_stb_o), 32'd0);
    chk("async reset grant_o", 32'(grant_o), 32'd0);
    s_ack_i = 1'b1;
    s_err_i = 1'b1;
    #1;
    chk("reset m1_ack_o suppressed", 32'(m1_ack_o), 32'd0);
    chk("reset m1_err_o suppressed", 32'(m1_err_o), 32'd0);
    chk("reset m1_dat_o follows", m1_dat_o, 32'h0F0F0F0F);
    #2;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    chk("m0 expectations drained", 32'(q0.size()), 32'd0);
    chk("m1 expectations drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
